// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the hard-wired zero register index and the source-operand match helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic src_match(input logic use_src, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_src && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_MemRead;
  logic             mem_MemRead;
  logic             mem_MemWrite;
  logic             mem_Branch;
  logic             mem_taken;
  logic             dmem_ready;
  logic             dmem_req;
  logic             pc_write;
  logic             pc_src;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             ex_mem_flush;
  logic             mem_wb_write;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead,
           mem_MemRead, mem_MemWrite, mem_Branch, mem_taken, dmem_ready,
    input  dmem_req, pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_write, halted,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead,
           mem_MemRead, mem_MemWrite, mem_Branch, mem_taken, dmem_ready,
    output dmem_req, pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_write, halted,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, dmem wait freezes with a timeout that halts the core, perf counters.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WCNT_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(DMEM_TIMEOUT);

  state_e            state_q;
  state_e            state_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic [WCNT_W-1:0] wait_cnt_d;
  logic [WCNT_W-1:0] wait_inc_s;

  logic memop_s;
  logic in_halt_s;
  logic freeze_s;
  logic branch_s;
  logic hazard_s;
  logic load_use_s;

  assign memop_s   = bus.mem_MemRead | bus.mem_MemWrite;
  assign in_halt_s = (state_q == HALT);
  assign freeze_s  = !in_halt_s && memop_s && !bus.dmem_ready;
  assign branch_s  = !in_halt_s && !freeze_s && bus.mem_Branch && bus.mem_taken;
  assign hazard_s  = bus.ex_MemRead && (bus.ex_rd != REG_ZERO) &&
                     (src_match(bus.id_use_rs1, bus.id_rs1, bus.ex_rd) ||
                      src_match(bus.id_use_rs2, bus.id_rs2, bus.ex_rd));
  // A hazard seen alongside a taken branch belongs to the squashed path
  assign load_use_s = !in_halt_s && !freeze_s && !branch_s && hazard_s;
  assign wait_inc_s = wait_cnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};

  // Next state and wait counter
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (reset) begin
      state_d    = RUN;
      wait_cnt_d = '0;
    end else if (in_halt_s) begin
      state_d    = HALT;
      wait_cnt_d = wait_cnt_q;
    end else if (freeze_s) begin
      wait_cnt_d = wait_inc_s;
      state_d    = (wait_inc_s >= WAIT_LIMIT) ? HALT : WAIT_MEM;
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
    end
  end

  // FSM state and wait counter registers
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    wait_cnt_q <= wait_cnt_d;
  end

  // Pipe-register, PC and dmem controls; take effect in the same cycle
  always_comb begin
    bus.dmem_req     = 1'b0;
    bus.pc_write     = 1'b1;
    bus.pc_src       = 1'b0;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_write  = 1'b1;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_write = 1'b1;
    bus.ex_mem_flush = 1'b0;
    bus.mem_wb_write = 1'b1;
    if (reset) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_write  = 1'b0;
      bus.ex_mem_write = 1'b0;
      bus.mem_wb_write = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (in_halt_s || freeze_s) begin
      bus.dmem_req     = memop_s && !in_halt_s;
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_write  = 1'b0;
      bus.ex_mem_write = 1'b0;
      bus.mem_wb_write = 1'b0;
    end else if (branch_s) begin
      bus.dmem_req     = memop_s;
      bus.pc_src       = 1'b1;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (load_use_s) begin
      bus.dmem_req     = memop_s;
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_flush  = 1'b1;
    end else begin
      bus.dmem_req     = memop_s;
    end
  end

  assign bus.halted = in_halt_s && !reset;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk),
    .clr_i (reset),
    .inc_i (freeze_s || load_use_s || in_halt_s),
    .cnt_o (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk),
    .clr_i (reset),
    .inc_i (branch_s),
    .cnt_o (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a vector table for single-cycle
// hazard decisions plus hand-written freeze/timeout/reset sequences.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;
  localparam int TMO   = 4;

  // Output bit order: req, pc_write, pc_src, if_id_w, if_id_f, id_ex_w, id_ex_f,
  // ex_mem_w, ex_mem_f, mem_wb_w, halted
  localparam logic [10:0] O_NORM = 11'b0_1_0_1_0_1_0_1_0_1_0;
  localparam logic [10:0] O_MEM  = 11'b1_1_0_1_0_1_0_1_0_1_0;
  localparam logic [10:0] O_LU   = 11'b0_0_0_0_0_1_1_1_0_1_0;
  localparam logic [10:0] O_LUM  = 11'b1_0_0_0_0_1_1_1_0_1_0;
  localparam logic [10:0] O_BR   = 11'b0_1_1_1_1_1_1_1_1_1_0;
  localparam logic [10:0] O_BRM  = 11'b1_1_1_1_1_1_1_1_1_1_0;
  localparam logic [10:0] O_FRZ  = 11'b1_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] O_RST  = 11'b0_0_0_0_1_0_1_0_1_0_0;
  localparam logic [10:0] O_HALT = 11'b0_0_0_0_0_0_0_0_0_0_1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] exrd;
    logic       exmr;
    logic       mr;
    logic       mw;
    logic       br;
    logic       tk;
    logic       rdy;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [10:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [10:0] sb_q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.DMEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic [4:0] exrd,
                             input logic exmr, input logic mr, input logic mw,
                             input logic br, input logic tk, input logic rdy);
    in_t v;
    v = '{rst: rst, rs1: rs1, rs2: rs2, u1: u1, u2: u2, exrd: exrd, exmr: exmr,
          mr: mr, mw: mw, br: br, tk: tk, rdy: rdy};
    return v;
  endfunction

  function automatic in_t idle();
    return mk(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic in_t ld(input logic rst, input logic rdy);
    return mk(rst, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rdy);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, push the expectation, compare before the next edge
  task automatic step(input string name, input in_t v, input logic [10:0] exp);
    logic [10:0] act;
    logic [10:0] want;
    reset            = v.rst;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_use_rs1   = v.u1;
    bus.id_use_rs2   = v.u2;
    bus.ex_rd        = v.exrd;
    bus.ex_MemRead   = v.exmr;
    bus.mem_MemRead  = v.mr;
    bus.mem_MemWrite = v.mw;
    bus.mem_Branch   = v.br;
    bus.mem_taken    = v.tk;
    bus.dmem_ready   = v.rdy;
    sb_q.push_back(exp);
    @(negedge clk);
    act = {bus.dmem_req, bus.pc_write, bus.pc_src, bus.if_id_write, bus.if_id_flush,
           bus.id_ex_write, bus.id_ex_flush, bus.ex_mem_write, bus.ex_mem_flush,
           bus.mem_wb_write, bus.halted};
    want = sb_q.pop_front();
    check(name, 64'(act), 64'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name, input int s, input int f);
    check({name, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(s));
    check({name, ".flush_cnt"}, 64'(bus.flush_cnt), 64'(f));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"lu_rs1",      mk(1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_LU};
    vecs[1] = '{"lu_x0",       mk(1'b0, 5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_NORM};
    vecs[2] = '{"lu_rs2",      mk(1'b0, 5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_LU};
    vecs[3] = '{"rs1_unused",  mk(1'b0, 5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_NORM};
    vecs[4] = '{"no_load",     mk(1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_NORM};
    vecs[5] = '{"br_over_lu",  mk(1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), O_BR};
    vecs[6] = '{"br_not_tkn",  mk(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), O_NORM};
    vecs[7] = '{"mem_zero_wt", mk(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), O_MEM};
    vecs[8] = '{"br_mem_rdy",  mk(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1), O_BRM};
    vecs[9] = '{"lu_sw_rdy",   mk(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), O_LUM};

    @(posedge clk);
    #1;
    step("reset", ld(1'b1, 1'b0), O_RST);
    check_cnt("after_reset", 0, 0);

    step(vecs[0].name, vecs[0].in, vecs[0].exp);
    check_cnt("single_lu", 1, 0);
    for (int i = 1; i < 10; i++) begin
      step(vecs[i].name, vecs[i].in, vecs[i].exp);
    end
    check_cnt("table", 3, 2);

    // Three wait cycles then ready
    step("t4_rst", idle() | in_t'({1'b1, {($bits(in_t)-1){1'b0}}}), O_RST);
    for (int i = 0; i < 3; i++) step("t4_freeze", ld(1'b0, 1'b0), O_FRZ);
    step("t4_ready", ld(1'b0, 1'b1), O_MEM);
    step("t4_run", idle(), O_NORM);
    check_cnt("t4", 3, 0);

    // Timeout into HALT, then reset recovers
    step("t5_rst", ld(1'b1, 1'b0), O_RST);
    for (int i = 0; i < TMO; i++) step("t5_freeze", ld(1'b0, 1'b0), O_FRZ);
    step("t5_halt", ld(1'b0, 1'b0), O_HALT);
    step("t5_halt_rdy", ld(1'b0, 1'b1), O_HALT);
    check_cnt("t5_halted", TMO + 2, 0);
    step("t5_reset", ld(1'b1, 1'b0), O_RST);
    check_cnt("t5_cleared", 0, 0);
    step("t5_run", idle(), O_NORM);

    // Reset in the second WAIT_MEM cycle; wait counter must restart from zero
    step("t6_freeze1", ld(1'b0, 1'b0), O_FRZ);
    step("t6_freeze2", ld(1'b0, 1'b0), O_FRZ);
    step("t6_reset", ld(1'b1, 1'b0), O_RST);
    step("t6_run", idle(), O_NORM);
    check_cnt("t6_cleared", 0, 0);
    for (int i = 0; i < TMO - 1; i++) step("t6_refreeze", ld(1'b0, 1'b0), O_FRZ);
    step("t6_ready", ld(1'b0, 1'b1), O_MEM);
    check_cnt("t6_end", TMO - 1, 0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
